// File: rtl/otp_pad_scheduler_pkg.sv
// Shared definitions for the one-time-pad scheduler: FSM states and default sizes.
package otp_pad_scheduler_pkg;

  localparam int DEFAULT_SLOTS = 8;
  localparam int DEFAULT_W     = 8;

  typedef enum logic {
    RUN  = 1'b0,
    WIPE = 1'b1
  } state_t;

endpackage

// File: rtl/otp_slot_finder.sv
// Combinational round-robin search for the first empty pad slot at or after start.
module otp_slot_finder
  import otp_pad_scheduler_pkg::*;
#(
  parameter int SLOTS = DEFAULT_SLOTS
) (
  input  logic [SLOTS-1:0]         full,
  input  logic [$clog2(SLOTS)-1:0] start,
  output logic [$clog2(SLOTS)-1:0] slot,
  output logic                     found
);

  localparam int IW = $clog2(SLOTS);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest empty slot wins;
  // SLOTS is a power of two, so the index sum wraps naturally.
  always_comb begin
    slot  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      cand = start + IW'(k);
      if (!full[cand]) begin
        slot  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/otp_pad_scheduler.sv
// One-time-pad slot scheduler: encrypts into fresh pad slots, decrypts by
// consuming a slot exactly once, and can wipe all slots on request.
module otp_pad_scheduler
  import otp_pad_scheduler_pkg::*;
#(
  parameter int SLOTS = DEFAULT_SLOTS,
  parameter int W     = DEFAULT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enc_valid,
  output logic                     enc_ready,
  input  logic [W-1:0]             enc_data,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [$clog2(SLOTS)-1:0] dec_idx,
  input  logic [W-1:0]             dec_data,
  input  logic [W-1:0]             pad_in,
  output logic                     pad_take,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic [$clog2(SLOTS)-1:0] res_idx,
  output logic                     res_dec,
  output logic                     res_err,
  input  logic                     clear,
  output logic [$clog2(SLOTS):0]   free_cnt
);

  localparam int IW = $clog2(SLOTS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] SLOTS_CNT = CW'(SLOTS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(SLOTS - 1);

  state_t        state, state_next;
  logic [W-1:0]  mem [SLOTS];
  logic [SLOTS-1:0] full;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] wipe_idx;
  logic [IW-1:0] free_slot;
  logic          found;
  logic          prio_dec;
  logic          out_free;
  logic          enc_req, dec_req;
  logic          grant_enc, grant_dec;
  logic          dec_hit;

  otp_slot_finder #(.SLOTS(SLOTS)) u_finder (
    .full  (full),
    .start (wr_ptr),
    .slot  (free_slot),
    .found (found)
  );

  // The output register is free when empty or being drained this cycle.
  assign out_free  = !res_valid || res_ready;
  assign enc_ready = (state == RUN) && out_free && (free_cnt != '0) && !clear;
  assign dec_ready = (state == RUN) && out_free && !clear;

  assign enc_req   = enc_valid && enc_ready;
  assign dec_req   = dec_valid && dec_ready;
  assign grant_dec = dec_req && (!enc_req || prio_dec);
  assign grant_enc = enc_req && found && !grant_dec;
  assign dec_hit   = full[dec_idx];
  assign pad_take  = grant_enc && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (clear) state_next = WIPE;
      WIPE:    if (wipe_idx == LAST_IDX) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Slot storage, allocation pointer, free count, arbitration flag and
  // result register. Grants are impossible during WIPE, so the wipe writes
  // and the grant writes never target the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      full      <= '0;
      wr_ptr    <= '0;
      wipe_idx  <= '0;
      prio_dec  <= 1'b1;
      free_cnt  <= SLOTS_CNT;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_dec   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      if (state == WIPE) begin
        mem[wipe_idx]  <= '0;
        full[wipe_idx] <= 1'b0;
        wipe_idx       <= wipe_idx + 1'b1;
        if (wipe_idx == LAST_IDX) begin
          free_cnt <= SLOTS_CNT;
          wr_ptr   <= '0;
        end
      end else begin
        wipe_idx <= '0;
      end

      if (enc_req && dec_req) prio_dec <= !grant_dec;

      if (grant_enc) begin
        mem[free_slot]  <= pad_in;
        full[free_slot] <= 1'b1;
        wr_ptr          <= free_slot + 1'b1;
        free_cnt        <= free_cnt - 1'b1;
      end

      if (grant_dec && dec_hit) begin
        mem[dec_idx]  <= '0;
        full[dec_idx] <= 1'b0;
        free_cnt      <= free_cnt + 1'b1;
      end

      if (grant_enc || grant_dec) begin
        res_valid <= 1'b1;
        res_data  <= grant_enc ? (pad_in ^ enc_data)
                               : (dec_hit ? (mem[dec_idx] ^ dec_data) : '0);
        res_idx   <= grant_enc ? free_slot : dec_idx;
        res_dec   <= grant_dec;
        res_err   <= grant_dec && !dec_hit;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Directed self-checking bench for otp_pad_scheduler (SLOTS=8, W=8).
module tb_otp_pad_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_valid = 1'b0, dec_valid = 1'b0, res_ready = 1'b1, clear = 1'b0;
  logic [7:0] enc_data = '0, dec_data = '0, pad_in = '0;
  logic [2:0] dec_idx = '0;
  logic       enc_ready, dec_ready, pad_take, res_valid, res_dec, res_err;
  logic [7:0] res_data;
  logic [2:0] res_idx;
  logic [3:0] free_cnt;

  int checks = 0;
  int passes = 0;

  otp_pad_scheduler #(.SLOTS(8), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .enc_data  (enc_data),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_idx   (dec_idx),
    .dec_data  (dec_data),
    .pad_in    (pad_in),
    .pad_take  (pad_take),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_dec   (res_dec),
    .res_err   (res_err),
    .clear     (clear),
    .free_cnt  (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL rst_res_valid: got %b expected 0", res_valid); else passes++;
    checks++; if (res_data !== 8'h00) $display("[TB] FAIL rst_res_data: got %h expected 00", res_data); else passes++;
    checks++; if (res_idx !== 3'd0) $display("[TB] FAIL rst_res_idx: got %0d expected 0", res_idx); else passes++;
    checks++; if (res_dec !== 1'b0 || res_err !== 1'b0) $display("[TB] FAIL rst_flags: got dec=%b err=%b expected 0 0", res_dec, res_err); else passes++;
    checks++; if (pad_take !== 1'b0) $display("[TB] FAIL rst_pad_take: got %b expected 0", pad_take); else passes++;
    checks++; if (free_cnt !== 4'd8) $display("[TB] FAIL rst_free_cnt: got %0d expected 8", free_cnt); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b1 || dec_ready !== 1'b1) $display("[TB] FAIL rst_readies: got enc=%b dec=%b expected 1 1", enc_ready, dec_ready); else passes++;
  endtask

  // 0x41 XOR pads 0x10..0x17
  task automatic test_encrypt_fill;
    logic [7:0] exp_ct [8];
    exp_ct = '{8'h51, 8'h50, 8'h53, 8'h52, 8'h55, 8'h54, 8'h57, 8'h56};
    for (int i = 0; i < 8; i++) begin
      enc_valid = 1'b1;
      enc_data  = 8'h41;
      pad_in    = 8'(8'h10 + i);
      #1;
      checks++; if (enc_ready !== 1'b1 || pad_take !== 1'b1) $display("[TB] FAIL enc_grant[%0d]: got ready=%b take=%b expected 1 1", i, enc_ready, pad_take); else passes++;
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== exp_ct[i]) $display("[TB] FAIL enc_data[%0d]: got v=%b %h expected v=1 %h", i, res_valid, res_data, exp_ct[i]); else passes++;
      checks++; if (res_idx !== 3'(i) || res_dec !== 1'b0 || res_err !== 1'b0) $display("[TB] FAIL enc_meta[%0d]: got idx=%0d dec=%b err=%b expected idx=%0d 0 0", i, res_idx, res_dec, res_err, i); else passes++;
      checks++; if (free_cnt !== 4'(7 - i)) $display("[TB] FAIL enc_free[%0d]: got %0d expected %0d", i, free_cnt, 7 - i); else passes++;
    end
    enc_valid = 1'b0;
    #1;
    checks++; if (enc_ready !== 1'b0) $display("[TB] FAIL enc_full_ready: got %b expected 0", enc_ready); else passes++;
  endtask

  // Slot 3 holds pad 0x13; its ciphertext from the fill was 0x52.
  task automatic test_decrypt;
    dec_valid = 1'b1;
    dec_idx   = 3'd3;
    dec_data  = 8'h52;
    #1;
    checks++; if (dec_ready !== 1'b1) $display("[TB] FAIL dec_ready: got %b expected 1", dec_ready); else passes++;
    tick();
    checks++; if (res_data !== 8'h41 || res_idx !== 3'd3) $display("[TB] FAIL dec_result: got %h idx=%0d expected 41 idx=3", res_data, res_idx); else passes++;
    checks++; if (res_dec !== 1'b1 || res_err !== 1'b0 || free_cnt !== 4'd1) $display("[TB] FAIL dec_flags: got dec=%b err=%b free=%0d expected 1 0 1", res_dec, res_err, free_cnt); else passes++;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h00 || res_idx !== 3'd3) $display("[TB] FAIL dec_reuse_data: got v=%b %h idx=%0d expected v=1 00 idx=3", res_valid, res_data, res_idx); else passes++;
    checks++; if (res_dec !== 1'b1 || res_err !== 1'b1 || free_cnt !== 4'd1) $display("[TB] FAIL dec_reuse_flags: got dec=%b err=%b free=%0d expected 1 1 1", res_dec, res_err, free_cnt); else passes++;
    dec_valid = 1'b0;
  endtask

  // Both requesters held: first contest goes to decrypt, then alternate.
  task automatic test_back_to_back;
    logic       exp_dec  [4];
    logic [7:0] exp_data [4];
    logic [2:0] exp_idx  [4];
    logic [3:0] exp_free [4];
    exp_dec  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_data = '{8'h41, 8'h61, 8'h71, 8'h61};
    exp_idx  = '{3'd0, 3'd0, 3'd0, 3'd3};
    exp_free = '{4'd2, 4'd1, 4'd2, 4'd1};
    enc_valid = 1'b1; enc_data = 8'h41; pad_in = 8'h20;
    dec_valid = 1'b1; dec_idx = 3'd0; dec_data = 8'h51;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (res_dec !== exp_dec[k] || res_data !== exp_data[k]) $display("[TB] FAIL b2b_grant[%0d]: got dec=%b %h expected dec=%b %h", k, res_dec, res_data, exp_dec[k], exp_data[k]); else passes++;
      checks++; if (res_idx !== exp_idx[k] || free_cnt !== exp_free[k]) $display("[TB] FAIL b2b_state[%0d]: got idx=%0d free=%0d expected idx=%0d free=%0d", k, res_idx, free_cnt, exp_idx[k], exp_free[k]); else passes++;
    end
  endtask

  // Result from the last contest (0x61, slot 3) must hold under backpressure.
  task automatic test_backpressure;
    res_ready = 1'b0;
    dec_idx = 3'd1; dec_data = 8'h50;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (enc_ready !== 1'b0 || dec_ready !== 1'b0) $display("[TB] FAIL bp_readies[%0d]: got enc=%b dec=%b expected 0 0", k, enc_ready, dec_ready); else passes++;
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h61 || res_idx !== 3'd3 || res_dec !== 1'b0) $display("[TB] FAIL bp_hold[%0d]: got v=%b %h idx=%0d dec=%b expected v=1 61 idx=3 dec=0", k, res_valid, res_data, res_idx, res_dec); else passes++;
    end
    res_ready = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", dec_ready); else passes++;
    tick();
    checks++; if (res_data !== 8'h41 || res_idx !== 3'd1 || res_dec !== 1'b1 || free_cnt !== 4'd2) $display("[TB] FAIL bp_release_result: got %h idx=%0d dec=%b free=%0d expected 41 idx=1 dec=1 free=2", res_data, res_idx, res_dec, free_cnt); else passes++;
    enc_valid = 1'b0;
    dec_valid = 1'b0;
  endtask

  task automatic test_clear;
    dec_valid = 1'b1; dec_idx = 3'd2; dec_data = 8'h00;
    tick();
    checks++; if (res_data !== 8'h12 || free_cnt !== 4'd3) $display("[TB] FAIL clr_setup: got %h free=%0d expected 12 free=3", res_data, free_cnt); else passes++;
    dec_valid = 1'b0;
    res_ready = 1'b0;
    clear = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b0 || dec_ready !== 1'b0) $display("[TB] FAIL clr_sample_readies: got enc=%b dec=%b expected 0 0", enc_ready, dec_ready); else passes++;
    tick();
    for (int k = 0; k < 8; k++) begin
      enc_valid = 1'b1;
      dec_valid = 1'b1;
      clear     = (k < 7);
      res_ready = (k >= 2);
      #1;
      checks++; if (enc_ready !== 1'b0 || dec_ready !== 1'b0) $display("[TB] FAIL wipe_readies[%0d]: got enc=%b dec=%b expected 0 0", k, enc_ready, dec_ready); else passes++;
      if (k <= 2) begin
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h12) $display("[TB] FAIL wipe_pending[%0d]: got v=%b %h expected v=1 12", k, res_valid, res_data); else passes++;
      end
      if (k == 3) begin
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL wipe_drained: got %b expected 0", res_valid); else passes++;
      end
      tick();
    end
    dec_valid = 1'b0;
    enc_data = 8'h41; pad_in = 8'h30;
    checks++; if (free_cnt !== 4'd8) $display("[TB] FAIL wipe_free: got %0d expected 8", free_cnt); else passes++;
    #1;
    checks++; if (enc_ready !== 1'b1) $display("[TB] FAIL wipe_run_ready: got %b expected 1", enc_ready); else passes++;
    tick();
    checks++; if (res_idx !== 3'd0 || res_data !== 8'h71 || free_cnt !== 4'd7) $display("[TB] FAIL wipe_next_enc: got idx=%0d %h free=%0d expected idx=0 71 free=7", res_idx, res_data, free_cnt); else passes++;
    enc_valid = 1'b0;
    dec_valid = 1'b1; dec_idx = 3'd4; dec_data = 8'h00;
    tick();
    checks++; if (res_err !== 1'b1 || res_data !== 8'h00 || free_cnt !== 4'd7) $display("[TB] FAIL wipe_slot_empty: got err=%b %h free=%0d expected err=1 00 free=7", res_err, res_data, free_cnt); else passes++;
    dec_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wipe;
    enc_valid = 1'b1; enc_data = 8'h00; pad_in = 8'h40; res_ready = 1'b1;
    tick();
    enc_valid = 1'b0;
    res_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h40) $display("[TB] FAIL rmw_pending: got v=%b %h expected v=1 40", res_valid, res_data); else passes++;
    rst_n = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00 || free_cnt !== 4'd8) $display("[TB] FAIL rmw_after_reset: got v=%b %h free=%0d expected v=0 00 free=8", res_valid, res_data, free_cnt); else passes++;
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    checks++; if (enc_ready !== 1'b1 || dec_ready !== 1'b1) $display("[TB] FAIL rmw_run: got enc=%b dec=%b expected 1 1", enc_ready, dec_ready); else passes++;
    dec_valid = 1'b1; dec_idx = 3'd0; dec_data = 8'h00;
    tick();
    checks++; if (res_err !== 1'b1 || res_dec !== 1'b1) $display("[TB] FAIL rmw_slots_empty: got err=%b dec=%b expected 1 1", res_err, res_dec); else passes++;
    dec_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encrypt_fill();
    test_decrypt();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid_wipe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
